// File: rtl/cpu_multicycle.sv
// cpu_multicycle: parametrised multi-cycle FETCH/DECODE/EXECUTE core.
// Ports: clock/isReset, fetch handshake (fetchRequest/pc out,
// fetchInstruction/fetchValid in), switch, resume, debugSelect ->
// register1Value, and status outputs carryFlag, halted, retired.
module cpu_multicycle #(
    parameter int REGISTER_WIDTH      = 8,
    parameter int NUMBER_OF_REGISTERS = 8,
    parameter int PC_WIDTH            = 8,
    localparam int RIDX = $clog2(NUMBER_OF_REGISTERS),
    localparam int INSTRUCTION_WIDTH = 4 + 2 * RIDX + REGISTER_WIDTH
) (
    input  logic                         clock,
    input  logic                         isReset,
    input  logic                         switch,
    input  logic [INSTRUCTION_WIDTH-1:0] fetchInstruction,
    input  logic                         fetchValid,
    output logic                         fetchRequest,
    output logic [PC_WIDTH-1:0]          pc,
    input  logic                         resume,
    input  logic [RIDX-1:0]              debugSelect,
    output logic [REGISTER_WIDTH-1:0]    register1Value,
    output logic                         carryFlag,
    output logic                         halted,
    output logic                         retired
);

    localparam int RW = REGISTER_WIDTH;
    localparam int IW = INSTRUCTION_WIDTH;
    localparam int JW = (PC_WIDTH > RW) ? PC_WIDTH : RW;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_LSH  = 4'h4;
    localparam logic [3:0] OP_RSH  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_LDSW = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hB;
    localparam logic [3:0] OP_RST  = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALTED
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0] instr;
    logic [RW-1:0] regs [NUMBER_OF_REGISTERS];
    logic [RW-1:0] operand_a;
    logic [RW-1:0] operand_b;

    logic [3:0]      op;
    logic [RIDX-1:0] rd;
    logic [RIDX-1:0] rs1;
    logic [RIDX-1:0] rs2;
    logic [RW-1:0]   imm;

    assign op  = instr[IW-1 -: 4];
    assign rd  = instr[IW-5 -: RIDX];
    assign rs1 = instr[IW-5-RIDX -: RIDX];
    assign imm = instr[RW-1:0];
    assign rs2 = imm[RIDX-1:0];

    // Register 0 is hard-wired to zero on every read path.
    logic [RW-1:0] rs1_val;
    logic [RW-1:0] rs2_val;

    assign rs1_val = (rs1 == '0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == '0) ? '0 : regs[rs2];
    assign register1Value = (debugSelect == '0) ? '0 : regs[debugSelect];

    assign fetchRequest = (state == S_FETCH) & ~isReset;
    assign halted       = (state == S_HALTED);

    // Jump target: immediate truncated or zero-extended to the pc width.
    logic [JW-1:0]       imm_wide;
    logic [PC_WIDTH-1:0] jump_target;

    assign imm_wide    = JW'(imm);
    assign jump_target = imm_wide[PC_WIDTH-1:0];

    // One extra bit captures carry-out on ADD and borrow on SUB.
    logic [RW:0] sum;
    logic [RW:0] diff;

    assign sum  = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff = {1'b0, operand_a} - {1'b0, operand_b};

    logic                wb_en;
    logic [RW-1:0]       wb_val;
    logic                carry_en;
    logic                carry_val;
    logic                clear_all;
    logic [PC_WIDTH-1:0] pc_next;

    always_comb begin
        wb_en     = 1'b0;
        wb_val    = '0;
        carry_en  = 1'b0;
        carry_val = 1'b0;
        clear_all = 1'b0;
        pc_next   = pc + PC_WIDTH'(1);
        case (op)
            OP_LDI: begin
                wb_en  = 1'b1;
                wb_val = imm;
            end
            OP_ADD: begin
                wb_en     = 1'b1;
                wb_val    = sum[RW-1:0];
                carry_en  = 1'b1;
                carry_val = sum[RW];
            end
            OP_SUB: begin
                wb_en     = 1'b1;
                wb_val    = diff[RW-1:0];
                carry_en  = 1'b1;
                carry_val = diff[RW];
            end
            OP_LSH: begin
                wb_en  = 1'b1;
                wb_val = operand_a << 1;
            end
            OP_RSH: begin
                wb_en  = 1'b1;
                wb_val = operand_a >> 1;
            end
            OP_INC: begin
                wb_en  = 1'b1;
                wb_val = operand_a + RW'(1);
            end
            OP_DEC: begin
                wb_en  = 1'b1;
                wb_val = operand_a - RW'(1);
            end
            OP_LDSW: begin
                wb_en  = 1'b1;
                wb_val = RW'(switch);
            end
            OP_JMP: pc_next = jump_target;
            OP_JZ: begin
                if (operand_a == '0) pc_next = jump_target;
            end
            OP_RST: begin
                clear_all = 1'b1;
                carry_en  = 1'b1;
                pc_next   = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:   if (fetchValid) state_next = S_DECODE;
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = (op == OP_HALT) ? S_HALTED : S_FETCH;
            S_HALTED:  if (resume) state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge isReset) begin
        if (isReset) begin
            state     <= S_FETCH;
            pc        <= '0;
            instr     <= '0;
            operand_a <= '0;
            operand_b <= '0;
            carryFlag <= 1'b0;
            retired   <= 1'b0;
            for (int i = 0; i < NUMBER_OF_REGISTERS; i++) regs[i] <= '0;
        end else begin
            state   <= state_next;
            retired <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (fetchValid) instr <= fetchInstruction;
                end
                S_DECODE: begin
                    operand_a <= rs1_val;
                    operand_b <= rs2_val;
                end
                S_EXECUTE: begin
                    retired <= 1'b1;
                    pc      <= pc_next;
                    if (carry_en) carryFlag <= carry_val;
                    if (clear_all) begin
                        for (int i = 0; i < NUMBER_OF_REGISTERS; i++) regs[i] <= '0;
                    end else if (wb_en && rd != '0) begin
                        regs[rd] <= wb_val;
                    end
                end
                S_HALTED: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed self-checking bench for cpu_multicycle.
// A small instruction memory answers fetches with a chosen wait count.
module tb_cpu_multicycle;

    localparam int RW   = 8;
    localparam int NR   = 8;
    localparam int PW   = 8;
    localparam int RIDX = 3;
    localparam int IW   = 18;

    logic            clock = 1'b0;
    logic            isReset = 1'b1;
    logic            switch = 1'b0;
    logic [IW-1:0]   fetchInstruction = '0;
    logic            fetchValid = 1'b0;
    logic            fetchRequest;
    logic [PW-1:0]   pc;
    logic            resume = 1'b0;
    logic [RIDX-1:0] debugSelect = '0;
    logic [RW-1:0]   register1Value;
    logic            carryFlag;
    logic            halted;
    logic            retired;

    logic [IW-1:0] mem [256];

    int errors = 0;
    int checks = 0;
    int n_ret  = 0;

    always #5 clock = ~clock;

    cpu_multicycle #(
        .REGISTER_WIDTH(RW),
        .NUMBER_OF_REGISTERS(NR),
        .PC_WIDTH(PW)
    ) dut (
        .clock(clock),
        .isReset(isReset),
        .switch(switch),
        .fetchInstruction(fetchInstruction),
        .fetchValid(fetchValid),
        .fetchRequest(fetchRequest),
        .pc(pc),
        .resume(resume),
        .debugSelect(debugSelect),
        .register1Value(register1Value),
        .carryFlag(carryFlag),
        .halted(halted),
        .retired(retired)
    );

    always @(negedge clock) if (retired) n_ret++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [IW-1:0] enc(input int op, input int rd,
                                          input int rs1, input int imm);
        return {op[3:0], rd[2:0], rs1[2:0], imm[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int idx, input int exp);
        debugSelect = idx[RIDX-1:0];
        #1;
        chk(tag, 32'(register1Value), exp);
    endtask

    // Serve one fetch after w wait cycles, then wait for the retire pulse.
    task automatic step(input int w);
        int k;
        k = 0;
        while (!fetchRequest && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (!fetchRequest) begin
            chk("fetch_timeout", 32'(fetchRequest), 1);
            return;
        end
        repeat (w) @(negedge clock);
        fetchInstruction = mem[pc];
        fetchValid = 1'b1;
        @(negedge clock);
        fetchValid = 1'b0;
        k = 1;
        while (!retired && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("retire_latency", k, 3);
    endtask

    initial begin
        int n;
        int bad;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0]   = enc(1, 1, 0, 5);
        mem[1]   = enc(1, 2, 0, 250);
        mem[2]   = enc(2, 3, 1, 2);
        mem[3]   = enc(2, 3, 3, 1);
        mem[4]   = enc(1, 0, 0, 7);
        mem[5]   = enc(1, 1, 0, 3);
        mem[6]   = enc(7, 1, 1, 0);
        mem[7]   = enc(10, 0, 1, 10);
        mem[8]   = enc(9, 0, 0, 6);
        mem[10]  = enc(9, 0, 0, 5);
        mem[16]  = enc(11, 0, 0, 0);
        mem[17]  = enc(9, 0, 0, 255);
        mem[255] = enc(0, 0, 0, 0);

        isReset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_fetchreq", 32'(fetchRequest), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_carry", 32'(carryFlag), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_retired", 32'(retired), 0);
        chk_reg("rst_r1", 1, 0);
        isReset = 1'b0;
        #1;
        chk("post_rst_fetchreq", 32'(fetchRequest), 1);
        @(negedge clock);

        step(1);
        chk_reg("ldi_r1", 1, 5);
        step(1);
        chk_reg("ldi_r2", 2, 250);
        step(1);
        chk_reg("add_r3", 3, 255);
        chk("add_carry0", 32'(carryFlag), 0);
        step(1);
        chk_reg("add_wrap_r3", 3, 4);
        chk("add_carry1", 32'(carryFlag), 1);
        chk("retire_count", n_ret, 4);
        chk("pc_after4", 32'(pc), 4);

        step(1);
        chk_reg("r0_zero", 0, 0);
        chk("pc_after_r0", 32'(pc), 5);

        n = 0;
        do begin
            step(1);
            n++;
        end while (pc != 8'd10 && n < 20);
        chk("loop_steps", n, 9);
        chk("loop_pc", 32'(pc), 10);
        chk_reg("loop_r1", 1, 0);
        chk("dec_keeps_carry", 32'(carryFlag), 1);

        step(1);
        chk("jmp_back_pc", 32'(pc), 5);
        mem[10] = enc(9, 0, 0, 16);

        resume = 1'b1;
        n = 0;
        do begin
            step(5);
            n++;
        end while (pc != 8'd10 && n < 20);
        resume = 1'b0;
        chk("wait_loop_steps", n, 9);
        chk("wait_loop_pc", 32'(pc), 10);
        chk_reg("wait_loop_r1", 1, 0);
        chk("wait_halted", 32'(halted), 0);

        step(1);
        chk("jmp_pc16", 32'(pc), 16);
        step(1);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_pc", 32'(pc), 17);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (fetchRequest) bad++;
        end
        chk("halt_noreq", bad, 0);
        chk("halt_hold", 32'(halted), 1);

        resume = 1'b1;
        @(negedge clock);
        resume = 1'b0;
        chk("resume_req", 32'(fetchRequest), 1);
        chk("resume_pc", 32'(pc), 17);
        chk("resume_halted", 32'(halted), 0);

        step(1);
        chk("jmp_ff", 32'(pc), 255);
        step(1);
        chk("pc_wrap", 32'(pc), 0);

        mem[0] = enc(8, 4, 0, 0);
        mem[1] = enc(15, 0, 0, 0);
        switch = 1'b1;
        step(1);
        switch = 1'b0;
        chk_reg("ldsw_r4", 4, 1);
        chk_reg("pre_rst_r3", 3, 4);
        step(1);
        chk_reg("rstop_r2", 2, 0);
        chk_reg("rstop_r3", 3, 0);
        chk_reg("rstop_r4", 4, 0);
        chk("rstop_carry", 32'(carryFlag), 0);
        chk("rstop_pc", 32'(pc), 0);

        mem[0] = enc(1, 2, 0, 7);
        mem[1] = enc(2, 1, 2, 2);
        step(1);
        chk_reg("abort_pre_r2", 2, 7);
        chk("abort_pre_pc", 32'(pc), 1);
        @(negedge clock);
        fetchInstruction = mem[pc];
        fetchValid = 1'b1;
        @(negedge clock);
        fetchValid = 1'b0;
        @(negedge clock);
        #2;
        isReset = 1'b1;
        #1;
        chk("abort_fetchreq", 32'(fetchRequest), 0);
        chk("abort_pc", 32'(pc), 0);
        chk_reg("abort_r1", 1, 0);
        @(negedge clock);
        chk("abort_hold_req", 32'(fetchRequest), 0);
        chk("abort_retired", 32'(retired), 0);
        chk_reg("abort_hold_r1", 1, 0);
        isReset = 1'b0;
        #1;
        chk("abort_release_req", 32'(fetchRequest), 1);
        @(negedge clock);
        step(1);
        chk_reg("recover_r2", 2, 7);
        chk("recover_pc", 32'(pc), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
